// File: rtl/aes_ocm_pkg.sv
// Shared definitions for the on-chip-memory block reader: default widths,
// beats per memory word and the reader FSM state type.
package aes_ocm_pkg;

  localparam int DEF_DATA_W    = 1024;
  localparam int DEF_BEAT_W    = 128;
  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_MEM_DEPTH = 3601;

  localparam int BEATS_PER_WORD = DEF_DATA_W / DEF_BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } ocm_rd_state_t;

  // Width of an index able to count n items (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_ocm_word_serializer.sv
// Output word register for the block reader. Holds one memory word and
// presents it as consecutive beats, lowest beat first. The word register
// shifts down by one beat per accepted beat so st_data is taken straight
// from flop outputs. With AES_OCM_READER_BYTESWAP_EN defined each beat is
// byte-reversed on the way out (byte 0 lands in the top byte).
//
// Stream handshake: a beat transfers on a clock edge where st_valid and
// st_ready are both high; while st_ready is low, st_valid/st_data/st_last
// hold their values. load may only be asserted when the register is empty
// or its final beat is transferring in the same cycle (word_done).
module aes_ocm_word_serializer
  import aes_ocm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              st_ready,
  output logic [BEAT_W-1:0] st_data,
  output logic              st_valid,
  output logic              st_last,
  output logic              word_done
);

  localparam int BEATS = DATA_W / BEAT_W;
  localparam int IDX_W = idx_width(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              valid_q, valid_d;
  logic              last_word_q, last_word_d;
  logic              st_last_q, st_last_d;
  logic              accept;

  assign accept    = valid_q & st_ready;
  assign word_done = accept & (beat_q == LAST_IDX);
  assign st_valid  = valid_q;
  assign st_last   = st_last_q;

  // Advance on an accepted beat, then let a load override with a fresh word.
  always_comb begin
    word_d      = word_q;
    beat_d      = beat_q;
    valid_d     = valid_q;
    last_word_d = last_word_q;
    if (accept) begin
      word_d = word_q >> BEAT_W;
      beat_d = beat_q + IDX_W'(1);
      if (beat_q == LAST_IDX) begin
        beat_d      = '0;
        valid_d     = 1'b0;
        last_word_d = 1'b0;
      end
    end
    if (load) begin
      word_d      = load_data;
      beat_d      = '0;
      valid_d     = 1'b1;
      last_word_d = load_last;
    end
    st_last_d = valid_d & (beat_d == LAST_IDX) & last_word_d;
  end

  // Word register, beat index and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q      <= '0;
      beat_q      <= '0;
      valid_q     <= 1'b0;
      last_word_q <= 1'b0;
      st_last_q   <= 1'b0;
    end else begin
      word_q      <= word_d;
      beat_q      <= beat_d;
      valid_q     <= valid_d;
      last_word_q <= last_word_d;
      st_last_q   <= st_last_d;
    end
  end

`ifdef AES_OCM_READER_BYTESWAP_EN
  // Byte-reverse the current beat for big-endian AES state ordering.
  always_comb begin
    st_data = '0;
    for (int i = 0; i < BEAT_W / 8; i++) begin
      st_data[BEAT_W-1-8*i -: 8] = word_q[8*i +: 8];
    end
  end
`else
  assign st_data = word_q[BEAT_W-1:0];
`endif

endmodule

// File: rtl/aes_ocm_block_reader.sv
// Avalon-MM read master on port 2 of the 1024-bit on-chip buffer. On start
// it reads word_count consecutive words from base_addr (wrapping at
// MEM_DEPTH) and streams each as DATA_W/BEAT_W beats to the AES core.
// One prefetch register keeps the stream gap-free at one beat per cycle.
// Optional macro: AES_OCM_READER_BYTESWAP_EN (byte-reverse each beat).
//
// Memory side: mem_chipselect is high for exactly one cycle per word and
// mem_readdata is valid in the following cycle only; a read is launched
// when words remain, nothing is in flight and the prefetch slot is free.
module aes_ocm_block_reader
  import aes_ocm_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BEAT_W    = DEF_BEAT_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [BEAT_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  ocm_rd_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic              cs_q, cs_d;
  logic              due_q, due_d;
  logic [DATA_W-1:0] pf_q, pf_d;
  logic              pf_valid_q, pf_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ser_load;
  logic [DATA_W-1:0] ser_load_data;
  logic              ser_load_last;
  logic              ser_word_done;
  logic              space_ok;
  logic              load_from_pf;
  logic              load_from_mem;

  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // The output register can take a word when empty or finishing its last beat.
  assign space_ok      = ~st_valid | ser_word_done;
  assign load_from_pf  = (state_q == ST_STREAM) & pf_valid_q & space_ok;
  assign load_from_mem = due_q & ~pf_valid_q & space_ok;

  // Next-state, read issue, prefetch steering and status outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    cs_d          = 1'b0;
    due_d         = cs_q;
    pf_d          = pf_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ser_load      = 1'b0;
    ser_load_data = mem_readdata;
    ser_load_last = 1'b0;

    // The presented address moves on once its read has gone out.
    if (cs_q) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end

    // A word is final when nothing else is left to read or in flight.
    if (load_from_pf) begin
      ser_load      = 1'b1;
      ser_load_data = pf_q;
      ser_load_last = (remain_q == '0) & ~cs_q & ~due_q;
    end else if (load_from_mem) begin
      ser_load      = 1'b1;
      ser_load_data = mem_readdata;
      ser_load_last = (remain_q == '0) & ~cs_q;
    end

    pf_valid_d = (pf_valid_q & ~load_from_pf) | (due_q & ~load_from_mem);
    if (due_q & ~load_from_mem) begin
      pf_d = mem_readdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          addr_d = base_addr;
          if (word_count != '0) begin
            cs_d     = 1'b1;
            remain_d = word_count - ADDR_W'(1);
            state_d  = ST_FETCH;
          end else begin
            remain_d = '0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (load_from_mem) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (st_valid & st_ready & st_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Stay until the done pulse has been shown (covers the empty job).
        busy_d = 1'b0;
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (((state_q == ST_FETCH) | (state_q == ST_STREAM)) & (remain_q != '0) &
        ~cs_q & ~pf_valid_d) begin
      cs_d     = 1'b1;
      remain_d = remain_q - ADDR_W'(1);
    end
  end

  // Control and datapath registers; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      cs_q       <= 1'b0;
      due_q      <= 1'b0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      cs_q       <= cs_d;
      due_q      <= due_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  aes_ocm_word_serializer #(
    .DATA_W (DATA_W),
    .BEAT_W (BEAT_W)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data (ser_load_data),
    .load_last (ser_load_last),
    .st_ready  (st_ready),
    .st_data   (st_data),
    .st_valid  (st_valid),
    .st_last   (st_last),
    .word_done (ser_word_done)
  );

endmodule

// File: tb/tb_aes_ocm_block_reader.sv
// Directed bench for aes_ocm_block_reader with a memory model on port 2,
// an expected-beat queue filled at each start and drained by a stream
// monitor, plus cycle-accurate latency and address checks.
module tb_aes_ocm_block_reader;

  localparam int DATA_W    = 1024;
  localparam int BEAT_W    = 128;
  localparam int ADDR_W    = 12;
  localparam int MEM_DEPTH = 3601;
  localparam int BEATS     = DATA_W / BEAT_W;

  typedef logic [BEAT_W-1:0] cmp_t;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W-1:0]   word_count = '0;
  logic                busy, done;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect, mem_write, mem_clken;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_readdata = '0;
  logic [BEAT_W-1:0]   st_data;
  logic                st_valid, st_last;
  logic                st_ready = 1'b1;

  always #5 clk = ~clk;

  aes_ocm_block_reader #(
    .DATA_W(DATA_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_last(st_last)
  );

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] salt = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory contents model ----------------
  function automatic logic [DATA_W-1:0] mem_word(input int a);
    logic [DATA_W-1:0] w;
    logic [31:0]       x;
    w = '0;
    for (int b = 0; b < DATA_W / 32; b++) begin
      x = 32'(a) * 32'h9E37_79B1 + 32'(b) * 32'h85EB_CA6B;
      x = x ^ salt;
      x = x ^ (x >> 15);
      w[32*b +: 32] = x;
    end
    return w;
  endfunction

  function automatic logic [BEAT_W-1:0] model_beat(input logic [BEAT_W-1:0] b);
`ifdef AES_OCM_READER_BYTESWAP_EN
    logic [BEAT_W-1:0] r;
    for (int j = 0; j < BEAT_W / 8; j++) r[BEAT_W-1-8*j -: 8] = b[8*j +: 8];
    return r;
`else
    return b;
`endif
  endfunction

  // Read data is valid only in the cycle after the request; junk otherwise.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= mem_word(int'(mem_address));
    else                mem_readdata <= {(DATA_W/32){32'hDEAD_BEEF}};
  end

  // ---------------- scoreboard ----------------
  logic [BEAT_W:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [ADDR_W-1:0] got_addr[$];
  int                n_acc = 0;
  int                first_acc = -1;
  int                last_acc = -1;
  bit                mon_en = 1'b0;
  int                rdy_mode = 0;
  logic              prev_stall = 1'b0;
  logic [BEAT_W-1:0] prev_data = '0;

  task automatic check(input string tag, input cmp_t got, input cmp_t exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_job(input int base, input int wc);
    logic [DATA_W-1:0] w;
    int                a;
    for (int i = 0; i < wc; i++) begin
      a = (base + i) % MEM_DEPTH;
      exp_addr.push_back(ADDR_W'(a));
      w = mem_word(a);
      for (int k = 0; k < BEATS; k++) begin
        exp_q.push_back({(i == wc - 1) && (k == BEATS - 1), model_beat(w[BEAT_W*k +: BEAT_W])});
      end
    end
  endtask

  // Stream/memory monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [BEAT_W:0] e;
    if (mon_en && !reset) begin
      if (mem_chipselect) got_addr.push_back(mem_address);
      if (prev_stall) begin
        check("hold_valid", cmp_t'(st_valid), cmp_t'(1));
        check("hold_data", st_data, prev_data);
      end
      if (st_valid && st_ready) begin
        check("beat_expected", cmp_t'(exp_q.size() != 0), cmp_t'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", st_data, e[BEAT_W-1:0]);
          check("beat_last", cmp_t'(st_last), cmp_t'(e[BEAT_W]));
        end
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) st_ready = ~st_ready;
    else               st_ready = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int n;
    dcyc = -1;
    n = 0;
    while (n < budget && dcyc < 0) begin
      if (done) dcyc = cyc;
      else begin
        tick();
        n++;
      end
    end
    check("done_seen", cmp_t'(dcyc >= 0), cmp_t'(1));
  endtask

  task automatic clear_job();
    exp_q.delete();
    exp_addr.delete();
    got_addr.delete();
    n_acc = 0;
    first_acc = -1;
    last_acc = -1;
  endtask

  task automatic check_addrs();
    check("addr_count", cmp_t'(got_addr.size()), cmp_t'(exp_addr.size()));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      check("addr", cmp_t'(got_addr[i]), cmp_t'(exp_addr[i]));
  endtask

  task automatic run_job(input int base, input int wc, output int s_cyc, output int d_cyc);
    clear_job();
    push_job(base, wc);
    base_addr  = ADDR_W'(base);
    word_count = ADDR_W'(wc);
    start      = 1'b1;
    s_cyc      = cyc;
    tick();
    start = 1'b0;
    check("busy_s1", cmp_t'(busy), cmp_t'(1));
    check("cs_s1", cmp_t'(mem_chipselect), cmp_t'(wc != 0));
    if (wc != 0) check("addr_s1", cmp_t'(mem_address), cmp_t'(base));
    wait_done(400, d_cyc);
    check("busy_at_done", cmp_t'(busy), cmp_t'(0));
    tick();
    check("done_pulse", cmp_t'(done), cmp_t'(0));
    check("busy_after", cmp_t'(busy), cmp_t'(0));
    check("sb_empty", cmp_t'(exp_q.size()), cmp_t'(0));
    check_addrs();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, cmp_t'(busy), cmp_t'(0));
    check({tag, "_done"}, cmp_t'(done), cmp_t'(0));
    check({tag, "_cs"}, cmp_t'(mem_chipselect), cmp_t'(0));
    check({tag, "_valid"}, cmp_t'(st_valid), cmp_t'(0));
    check({tag, "_last"}, cmp_t'(st_last), cmp_t'(0));
    check({tag, "_addr"}, cmp_t'(mem_address), cmp_t'(0));
    check({tag, "_data"}, st_data, cmp_t'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s, d, rb;
    salt = $urandom;

    // Reset state and constant memory-port controls.
    reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    check("mem_write", cmp_t'(mem_write), cmp_t'(0));
    check("mem_clken", cmp_t'(mem_clken), cmp_t'(1));
    check("mem_be", cmp_t'(mem_byteenable), cmp_t'({(DATA_W/8){1'b1}}));
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Two words, sink always ready: exact latency and no gaps.
    rdy_mode = 0;
    run_job(32'h010, 2, s, d);
    check("first_beat_cyc", cmp_t'(first_acc), cmp_t'(s + 3));
    check("beats_no_gap", cmp_t'(last_acc - first_acc), cmp_t'(15));
    check("beat_count", cmp_t'(n_acc), cmp_t'(16));
    check("done_after_last", cmp_t'(d), cmp_t'(last_acc + 1));

    // One word, ready toggling every cycle.
    rdy_mode = 1;
    rb = $urandom_range(0, MEM_DEPTH - 1);
    run_job(rb, 1, s, d);
    check("toggle_beats", cmp_t'(n_acc), cmp_t'(8));
    check("toggle_done", cmp_t'(d), cmp_t'(last_acc + 1));
    rdy_mode = 0;
    tick();

    // Address wrap at the end of memory.
    run_job(3600, 2, s, d);
    check("wrap_beats", cmp_t'(n_acc), cmp_t'(16));

    // Empty job: done at S+2, no memory access.
    run_job(32'h123, 0, s, d);
    check("empty_done_cyc", cmp_t'(d), cmp_t'(s + 2));

    // Reset while beat 3 of a 3-word job is on the stream.
    clear_job();
    push_job(32'h200, 3);
    base_addr  = ADDR_W'(32'h200);
    word_count = ADDR_W'(3);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && n_acc < 3; i++) tick();
    check("reach_beat3", cmp_t'(n_acc), cmp_t'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midreset");
    clear_job();
    tick();
    rb = $urandom_range(0, MEM_DEPTH - 1);
    run_job(rb, 1, s, d);
    check("post_reset_beats", cmp_t'(n_acc), cmp_t'(8));

    // Start pulsed while busy must not alter the running job.
    clear_job();
    push_job(32'h300, 3);
    base_addr  = ADDR_W'(32'h300);
    word_count = ADDR_W'(3);
    start      = 1'b1;
    s          = cyc;
    tick();
    start = 1'b0;
    repeat (4) tick();
    base_addr  = ADDR_W'(32'h0AB);
    word_count = ADDR_W'(5);
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, d);
    check("busy_start_beats", cmp_t'(n_acc), cmp_t'(24));
    check("busy_start_done", cmp_t'(d), cmp_t'(s + 3 + 24));
    repeat (4) tick();
    check("busy_start_idle", cmp_t'(busy), cmp_t'(0));
    check("busy_start_sb", cmp_t'(exp_q.size()), cmp_t'(0));
    check_addrs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
